// File: rtl/rom_serial_responder.sv
// Serial 256x10 instruction ROM bank: locks to the 56-bit word frame, answers fetches on is_o.
// The optional delayed (armed) bank select is built when ROM_DELAYED_SELECT_EN is defined.
module rom_serial_responder #(
  parameter logic [2:0]               ROM_ID    = 3'd0,
  parameter int unsigned              ADR_W     = 8,
  parameter logic [10*(2**ADR_W)-1:0] ROM_IMAGE = '0
) (
  input  logic cph2,
  input  logic nrst,
  input  logic sync,
  input  logic ia,
  input  logic is_i,
  output logic is_o,
  output logic is_oe,
  output logic locked,
  output logic active
);

  localparam int unsigned Words = 2 ** ADR_W;

  localparam logic [5:0] CntFirst    = 6'd0;
  localparam logic [5:0] CntAdrFirst = 6'd19;
  localparam logic [5:0] CntAdrLast  = 6'd26;
  localparam logic [5:0] CntAdrLatch = 6'd27;
  localparam logic [5:0] CntRomRead  = 6'd28;
  localparam logic [5:0] CntLoad     = 6'd44;
  localparam logic [5:0] CntWinFirst = 6'd45;
  localparam logic [5:0] CntWinLast  = 6'd54;
  localparam logic [5:0] CntLast     = 6'd55;

  localparam logic [6:0] OpSelect    = 7'b0010000;
`ifdef ROM_DELAYED_SELECT_EN
  localparam logic [6:0] OpDelSelect = 7'b0110100;
`endif

  logic [9:0] rom_mem [Words];

  for (genvar g = 0; g < Words; g++) begin : g_rom
    assign rom_mem[g] = ROM_IMAGE[10*g +: 10];
  end

  logic [5:0]       cnt_q, cnt_d;
  logic             sync_q;
  logic             locked_q, locked_d;
  logic [ADR_W-1:0] adr_sr_q, adr_sr_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [9:0]       inst_q, inst_d;
  logic [9:0]       inst_sr_q, inst_sr_d;
  logic [9:0]       mon_sr_q, mon_sr_d;
  logic             drive_q, drive_d;
  logic             mon_ok_q, mon_ok_d;
  logic             sel_pend_q, sel_pend_d;
  logic             active_q, active_d;
`ifdef ROM_DELAYED_SELECT_EN
  logic             del_arm_q, del_arm_d;
  logic [2:0]       del_id_q, del_id_d;
`endif

  logic in_win;
  logic sync_rise;
  logic lock_ok;

  assign in_win    = (cnt_q >= CntWinFirst) && (cnt_q <= CntWinLast);
  assign sync_rise = sync && !sync_q;
  // Frame is trusted this cycle only if sync agrees with the counter's idea of the window.
  assign lock_ok   = locked_q && (sync == in_win);

  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      cnt_q      <= '0;
      // A pulse already high at reset release must not count as a rising edge.
      sync_q     <= 1'b1;
      locked_q   <= 1'b0;
      adr_sr_q   <= '0;
      adr_q      <= '0;
      inst_q     <= '0;
      inst_sr_q  <= '0;
      mon_sr_q   <= '0;
      drive_q    <= 1'b0;
      mon_ok_q   <= 1'b0;
      sel_pend_q <= (ROM_ID == 3'd0);
      active_q   <= (ROM_ID == 3'd0);
`ifdef ROM_DELAYED_SELECT_EN
      del_arm_q  <= 1'b0;
      del_id_q   <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      sync_q     <= sync;
      locked_q   <= locked_d;
      adr_sr_q   <= adr_sr_d;
      adr_q      <= adr_d;
      inst_q     <= inst_d;
      inst_sr_q  <= inst_sr_d;
      mon_sr_q   <= mon_sr_d;
      drive_q    <= drive_d;
      mon_ok_q   <= mon_ok_d;
      sel_pend_q <= sel_pend_d;
      active_q   <= active_d;
`ifdef ROM_DELAYED_SELECT_EN
      del_arm_q  <= del_arm_d;
      del_id_q   <= del_id_d;
`endif
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    locked_d   = locked_q;
    adr_sr_d   = adr_sr_q;
    adr_d      = adr_q;
    inst_d     = inst_q;
    inst_sr_d  = inst_sr_q;
    mon_sr_d   = mon_sr_q;
    drive_d    = drive_q;
    mon_ok_d   = mon_ok_q;
    sel_pend_d = sel_pend_q;
    active_d   = active_q;
`ifdef ROM_DELAYED_SELECT_EN
    del_arm_d  = del_arm_q;
    del_id_d   = del_id_q;
`endif

    if (sync_rise) begin
      cnt_d    = CntWinFirst + 6'd1;
      locked_d = 1'b1;
    end else begin
      cnt_d    = (cnt_q == CntLast) ? CntFirst : cnt_q + 6'd1;
      locked_d = lock_ok;
    end

    if (!lock_ok) begin
      // A partly driven or partly monitored window is abandoned outright.
      drive_d  = 1'b0;
      mon_ok_d = 1'b0;
    end else begin
      case (cnt_q) inside
        [CntAdrFirst:CntAdrLast]: adr_sr_d = {ia, adr_sr_q[ADR_W-1:1]};
        CntAdrLatch:              adr_d    = adr_sr_q;
        CntRomRead:               inst_d   = rom_mem[adr_q];
        CntLoad: begin
          drive_d  = active_q;
          mon_ok_d = 1'b1;
          if (active_q) inst_sr_d = inst_q;
        end
        [CntWinFirst:CntWinLast]: begin
          inst_sr_d = {1'b0, inst_sr_q[9:1]};
          mon_sr_d  = {is_i, mon_sr_q[9:1]};
        end
        CntLast: begin
          drive_d  = 1'b0;
          mon_ok_d = 1'b0;
          if (mon_ok_q) begin
            if (mon_sr_q[6:0] == OpSelect) begin
              sel_pend_d = (mon_sr_q[9:7] == ROM_ID);
`ifdef ROM_DELAYED_SELECT_EN
              del_arm_d  = 1'b0;
            end else if (mon_sr_q[6:0] == OpDelSelect) begin
              del_id_d   = mon_sr_q[9:7];
              del_arm_d  = 1'b1;
            end else if (del_arm_q && mon_sr_q[0]) begin
              sel_pend_d = (del_id_q == ROM_ID);
              del_arm_d  = 1'b0;
`endif
            end
          end
        end
        CntFirst: active_d = sel_pend_q;
        default: ;
      endcase
    end
  end

  assign is_oe  = drive_q & in_win & lock_ok;
  assign is_o   = is_oe & inst_sr_q[0];
  assign locked = locked_q;
  assign active = active_q;

endmodule
